// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings and condition evaluation for the multi-cycle control unit
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // flags are packed {N,Z,C,V}
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_holds = z;
      COND_NE: cond_holds = ~z;
      COND_CS: cond_holds = c;
      COND_CC: cond_holds = ~c;
      COND_MI: cond_holds = n;
      COND_PL: cond_holds = ~n;
      COND_VS: cond_holds = v;
      COND_VC: cond_holds = ~v;
      COND_HI: cond_holds = c & ~z;
      COND_LS: cond_holds = ~c | z;
      COND_GE: cond_holds = (n == v);
      COND_LT: cond_holds = (n != v);
      COND_GT: cond_holds = ~z & (n == v);
      COND_LE: cond_holds = z | (n != v);
      COND_AL: cond_holds = 1'b1;
      default: cond_holds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_cond_logic.sv
// rtl/mc_cond_logic.sv - NZCV flag register with split NZ/CV enables and CondEx evaluation
module mc_cond_logic
  import mc_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  output logic       CondEx
);

  logic [3:0] r_flags;

  // FlagW[1] loads N,Z and FlagW[0] loads C,V; a failed condition blocks both
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_flags <= FLAGS_RST;
    end else begin
      if (FlagW[1] && CondEx) r_flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && CondEx) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign CondEx = cond_holds(Cond, r_flags);

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle ARM control FSM with instruction decoders
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter bit         SUPPORT_CMP = 1'b1,
  parameter logic [3:0] FLAGS_RST   = 4'b0000,
  parameter int         STATE_W     = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUControl,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [1:0]         RegSrc,
  output logic [STATE_W-1:0] State
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_op;
  logic       w_i, w_s, w_u, w_l;
  logic [3:0] w_cmd, w_rd;
  logic [1:0] w_dp_ctrl;
  logic       w_dp_arith, w_dp_nowrite, w_dp_unsup;
  logic [1:0] w_flagw;
  logic       w_cond_ex;
  logic       w_pcw, w_memw, w_irw, w_regw;
  logic       w_unused;

  assign w_op  = Instr[27:26];
  assign w_i   = Instr[25];
  assign w_cmd = Instr[24:21];
  assign w_u   = Instr[23];
  assign w_s   = Instr[20];
  assign w_l   = Instr[20];
  assign w_rd  = Instr[15:12];
  assign w_unused = ^{Instr[19:16], Instr[11:0]};

  assign ImmSrc = Instr[27:26];
  assign RegSrc = {w_op == 2'b01, w_op == 2'b10};
  assign State  = STATE_W'(r_state);

  always_comb begin
    w_dp_ctrl    = ALU_ADD;
    w_dp_arith   = 1'b0;
    w_dp_nowrite = 1'b0;
    w_dp_unsup   = 1'b0;
    case (w_cmd)
      CMD_ADD: w_dp_arith = 1'b1;
      CMD_SUB: begin
        w_dp_ctrl  = ALU_SUB;
        w_dp_arith = 1'b1;
      end
      CMD_AND: w_dp_ctrl = ALU_AND;
      CMD_ORR: w_dp_ctrl = ALU_ORR;
      CMD_CMP: begin
        if (SUPPORT_CMP && w_s) begin
          w_dp_ctrl    = ALU_SUB;
          w_dp_arith   = 1'b1;
          w_dp_nowrite = 1'b1;
        end else begin
          w_dp_unsup   = 1'b1;
          w_dp_nowrite = 1'b1;
        end
      end
      default: begin
        w_dp_unsup   = 1'b1;
        w_dp_nowrite = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = FETCH;
    w_pcw      = 1'b0;
    w_memw     = 1'b0;
    w_irw      = 1'b0;
    w_regw     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RD2;
    w_flagw    = 2'b00;
    case (r_state)
      FETCH: begin
        w_irw     = 1'b1;
        w_pcw     = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        w_next    = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (w_op)
          2'b00:   w_next = w_i ? EXECUTEI : EXECUTER;
          2'b01:   w_next = MEMADR;
          2'b10:   w_next = BRANCH;
          default: w_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = w_u ? ALU_ADD : ALU_SUB;
        w_next     = w_l ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        w_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        w_regw    = w_cond_ex;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        w_memw = w_cond_ex;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB    = (r_state == EXECUTEI) ? SRCB_IMM : SRCB_RD2;
        ALUControl = w_dp_ctrl;
        // logical ops preserve C,V; unsupported commands leave flags alone
        w_flagw    = {w_s & ~w_dp_unsup, w_s & ~w_dp_unsup & w_dp_arith};
        w_next     = ALUWB;
      end
      ALUWB: begin
        w_regw = w_cond_ex & ~w_dp_nowrite;
        w_pcw  = w_cond_ex & (w_rd == 4'd15) & ~w_dp_nowrite;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        w_pcw     = w_cond_ex;
      end
      default: w_next = FETCH;
    endcase
  end

  // a reset cycle must never let the abandoned instruction commit anything
  assign PCWrite  = w_pcw  & ~RESET;
  assign MemWrite = w_memw & ~RESET;
  assign IRWrite  = w_irw  & ~RESET;
  assign RegWrite = w_regw & ~RESET;

  mc_cond_logic #(
    .FLAGS_RST(FLAGS_RST)
  ) u_cond (
    .CLK      (CLK),
    .RESET    (RESET),
    .Cond     (Instr[31:28]),
    .ALUFlags (ALUFlags),
    .FlagW    (w_flagw),
    .CondEx   (w_cond_ex)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed and randomized checks against an instruction-level model
module tb_multicycle_control_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0]  State;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] mflags  = 4'b0000;

  always #5 CLK = ~CLK;

  multicycle_control_unit #(
    .SUPPORT_CMP (1'b1),
    .FLAGS_RST   (4'b0000),
    .STATE_W     (4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .RegSrc     (RegSrc),
    .State      (State)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cy && !z;
      4'd9:    return !cy || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    mflags = 4'b0000;
  endtask

  // Runs one instruction from FETCH back to FETCH, checking every cycle.
  task automatic do_instr(input logic [31:0] ins, input logic [3:0] af);
    int         q[$];
    logic [1:0] op, ctrl;
    logic [3:0] cmd;
    logic       ce, s, nw, arith, unsup, pc_f, mem_f, reg_f, last, is_mem, is_br, is_dp;
    logic [1:0] exp_srcb, exp_res, exp_ctl;
    op = ins[27:26]; cmd = ins[24:21]; s = ins[20];
    ce = cond_ok(ins[31:28], mflags);
    ctrl = 2'd0; nw = 0; arith = 0; unsup = 0; pc_f = 0; mem_f = 0; reg_f = 0;
    is_dp = (op == 2'b00); is_mem = (op == 2'b01); is_br = (op == 2'b10);
    q = {0, 1};
    if (is_dp) begin
      q.push_back(ins[25] ? 7 : 6);
      q.push_back(8);
      case (cmd)
        4'b0100: arith = 1;
        4'b0010: begin ctrl = 2'd1; arith = 1; end
        4'b0000: ctrl = 2'd2;
        4'b1100: ctrl = 2'd3;
        4'b1010: if (s) begin ctrl = 2'd1; arith = 1; nw = 1; end
                 else begin unsup = 1; nw = 1; end
        default: begin unsup = 1; nw = 1; end
      endcase
      reg_f = ce && !nw;
      pc_f  = ce && !nw && (ins[15:12] == 4'd15);
    end else if (is_mem) begin
      ctrl = ins[23] ? 2'd0 : 2'd1;
      if (ins[20]) begin q.push_back(2); q.push_back(3); q.push_back(4); reg_f = ce; end
      else begin q.push_back(2); q.push_back(5); mem_f = ce; end
    end else if (is_br) begin
      q.push_back(9);
      pc_f = ce;
    end
    Instr = ins; ALUFlags = af;
    #1;
    chk("immsrc", 32'(ImmSrc), 32'(op));
    chk("regsrc", 32'(RegSrc), 32'({is_mem, is_br}));
    for (int k = 0; k < q.size(); k++) begin
      if (k > 0) #1;
      last = (k == q.size() - 1) && (q.size() > 2);
      exp_srcb = (k < 2) ? 2'b10 : (k == 2) ? ((is_dp && !ins[25]) ? 2'b00 : 2'b01) : 2'b00;
      exp_res  = (k < 2 || (is_br && k == 2)) ? 2'b10 : (is_mem && k == 4) ? 2'b01 : 2'b00;
      exp_ctl  = (k == 2 && (is_dp || is_mem)) ? ctrl : 2'b00;
      chk("state",    32'(State),      32'(q[k]));
      chk("irwrite",  32'(IRWrite),    32'(k == 0));
      chk("pcwrite",  32'(PCWrite),    32'((k == 0) || (last && pc_f)));
      chk("memwrite", 32'(MemWrite),   32'(last && mem_f));
      chk("regwrite", 32'(RegWrite),   32'(last && reg_f));
      chk("adrsrc",   32'(AdrSrc),     32'(is_mem && k == 3));
      chk("alusrca",  32'(ALUSrcA),    32'(k < 2));
      chk("alusrcb",  32'(ALUSrcB),    32'(exp_srcb));
      chk("resultsrc",32'(ResultSrc),  32'(exp_res));
      chk("aluctl",   32'(ALUControl), 32'(exp_ctl));
      @(negedge CLK);
    end
    if (is_dp && s && ce && !unsup) begin
      mflags[3:2] = af[3:2];
      if (arith) mflags[1:0] = af[1:0];
    end
    #1;
    if (State !== 4'd0) begin
      chk("resync", 32'(State), 32'd0);
      do_reset();
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] cond, cmd, rd;
    logic       s, i;
    int         sel;
    cond = 4'($urandom_range(0, 15));
    rd   = 4'($urandom_range(0, 15));
    case ($urandom_range(0, 4))
      0, 1: begin
        sel = $urandom_range(0, 5);
        case (sel)
          0: cmd = 4'b0100;
          1: cmd = 4'b0010;
          2: cmd = 4'b0000;
          3: cmd = 4'b1100;
          4: cmd = 4'b1010;
          default: cmd = (($urandom_range(0, 1) == 1) ? 4'b0001 : 4'b1000);
        endcase
        s = (sel == 4) ? 1'b1 : (sel == 5) ? 1'b0 : 1'($urandom_range(0, 1));
        if (s) cond = 4'hE;
        i = 1'($urandom_range(0, 1));
        return {cond, 2'b00, i, cmd, s, 4'h3, rd, 12'($urandom)};
      end
      2: return {cond, 2'b01, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 2'b00,
                 1'($urandom_range(0, 1)), 4'h5, rd, 12'($urandom)};
      3: return {cond, 2'b10, 2'b10, 24'($urandom)};
      default: return {cond, 2'b11, 26'($urandom)};
    endcase
  endfunction

  initial begin
    Instr = 32'h0; ALUFlags = 4'h0;
    do_reset();
    #1;
    chk("rst_state",    32'(State),    32'd0);
    chk("rst_irwrite",  32'(IRWrite),  32'd1);
    chk("rst_pcwrite",  32'(PCWrite),  32'd1);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);

    do_instr(32'hE0821003, 4'h0);
    do_instr(32'hE2532EFF, 4'b0100);
    do_instr(32'h10821003, 4'h0);
    do_instr(32'h00821003, 4'h0);
    do_instr(32'h1AFFFFFA, 4'h0);
    do_instr(32'hE585B004, 4'h0);
    do_instr(32'hE595B004, 4'h0);
    do_instr(32'hE2532EFF, 4'b0000);
    do_instr(32'h1AFFFFFA, 4'h0);

    Instr = 32'hE585B004;
    repeat (2) @(negedge CLK);
    #1;
    chk("midrst_memadr", 32'(State), 32'd2);
    RESET = 1'b1;
    #1;
    chk("midrst_mw0", 32'(MemWrite), 32'd0);
    @(negedge CLK);
    #1;
    chk("midrst_state", 32'(State),    32'd0);
    chk("midrst_mw1",   32'(MemWrite), 32'd0);
    RESET = 1'b0;
    mflags = 4'b0000;

    do_instr(32'hE1530004, 4'b0110);
    do_instr(32'h00821003, 4'h0);
    do_instr(32'h20821003, 4'h0);
    do_instr(32'hE082F003, 4'h0);

    for (int n = 0; n < 150; n++)
      do_instr(rand_instr(), 4'($urandom_range(0, 15)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
